// File: rtl/inst_buffer_if.sv
// Handshake bundle between the fetch unit, the instruction buffer and the decode stage.
// The buffer side uses the slave modport; the environment (fetch + decode) uses master.
interface inst_buffer_if #(
   parameter int FETCH_W = 64,
   parameter int PC_W    = 64
);
   logic               fetch_valid;
   logic               fetch_ready;
   logic [PC_W-1:0]    fetch_pc;
   logic [FETCH_W-1:0] fetch_data;
   logic               redirect;
   logic [PC_W-1:0]    redirect_pc;
   logic               inst_valid;
   logic               inst_ready;
   logic [31:0]        inst;
   logic               inst_compressed;
   logic [PC_W-1:0]    pc;

   modport slave (
      input  fetch_valid, fetch_pc, fetch_data, redirect, redirect_pc, inst_ready,
      output fetch_ready, inst_valid, inst, inst_compressed, pc
   );

   modport master (
      output fetch_valid, fetch_pc, fetch_data, redirect, redirect_pc, inst_ready,
      input  fetch_ready, inst_valid, inst, inst_compressed, pc
   );
endinterface

// File: rtl/inst_buffer.sv
// Instruction buffer: queues 16-bit parcels from aligned fetch blocks and presents
// complete 16-bit (compressed) or 32-bit instructions with their PC at the head.
module inst_buffer #(
   parameter int FETCH_W = 64,
   parameter int DEPTH   = 16,
   parameter int PC_W    = 64
) (
   input  logic          clk,
   input  logic          rst,
   inst_buffer_if.slave  bus
);
   localparam int P     = FETCH_W / 16;
   localparam int OFF_W = $clog2(FETCH_W / 8);
   localparam int SEL_W = OFF_W - 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [15:0]      r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;
   logic [PC_W-1:0]  r_head_pc;
   logic [PC_W-1:0]  r_exp_pc;

   logic [CNT_W-1:0] w_free;
   logic             w_fetch_ready;
   logic             w_accept;
   logic [PC_W-1:0]  w_exp_blk;
   logic             w_in_seq;
   logic             w_write;
   logic [SEL_W-1:0] w_off;
   logic [CNT_W-1:0] w_wr_cnt;
   logic [15:0]      w_h;
   logic [15:0]      w_n;
   logic             w_h_comp;
   logic             w_inst_valid;
   logic             w_pop;
   logic [CNT_W-1:0] w_pop_cnt;
   logic [31:0]      w_inst;
   logic             w_inst_comp;

   // Fetch-side acceptance: room for a whole block, and the block continues the stream.
   always_comb begin
      w_free        = CNT_W'(DEPTH) - r_count;
      w_fetch_ready = (w_free >= CNT_W'(P)) && !bus.redirect;
      w_accept      = bus.fetch_valid && w_fetch_ready;
      w_exp_blk     = {r_exp_pc[PC_W-1:OFF_W], {OFF_W{1'b0}}};
      w_in_seq      = (bus.fetch_pc == w_exp_blk);
      w_write       = w_accept && w_in_seq;
      w_off         = r_exp_pc[OFF_W-1:1];
      if (w_write) begin
         w_wr_cnt = CNT_W'(P) - CNT_W'(w_off);
      end else begin
         w_wr_cnt = {CNT_W{1'b0}};
      end
   end

   // Head decode; outputs are gated so that unwritten entries never reach the consumer.
   always_comb begin
      w_h      = r_mem[r_head];
      w_n      = r_mem[r_head + PTR_W'(1)];
      w_h_comp = (w_h[1:0] != 2'b11);
      if (r_count == {CNT_W{1'b0}}) begin
         w_inst_valid = 1'b0;
         w_inst_comp  = 1'b0;
      end else if (w_h_comp) begin
         w_inst_valid = 1'b1;
         w_inst_comp  = 1'b1;
      end else begin
         w_inst_valid = (r_count >= CNT_W'(2));
         w_inst_comp  = 1'b0;
      end
      if (!w_inst_valid) begin
         w_inst = 32'h0000_0000;
      end else if (w_h_comp) begin
         w_inst = {16'h0000, w_h};
      end else begin
         w_inst = {w_n, w_h};
      end
      w_pop = w_inst_valid && bus.inst_ready && !bus.redirect;
      if (!w_pop) begin
         w_pop_cnt = {CNT_W{1'b0}};
      end else if (w_h_comp) begin
         w_pop_cnt = CNT_W'(1);
      end else begin
         w_pop_cnt = CNT_W'(2);
      end
   end

   assign bus.fetch_ready     = w_fetch_ready;
   assign bus.inst_valid      = w_inst_valid;
   assign bus.inst            = w_inst;
   assign bus.inst_compressed = w_inst_comp;
   assign bus.pc              = r_head_pc;

   // Parcel storage; only the parcels at or after the expected offset are written.
   always_ff @(posedge clk) begin
      if (w_write) begin
         for (int k = 0; k < P; k++) begin
            if (SEL_W'(k) >= w_off) begin
               r_mem[r_tail + PTR_W'(k) - PTR_W'(w_off)] <= bus.fetch_data[16*k +: 16];
            end
         end
      end
   end

   // Pointers, occupancy and PCs; redirect overrides any same-cycle fetch or pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head    <= {PTR_W{1'b0}};
         r_tail    <= {PTR_W{1'b0}};
         r_count   <= {CNT_W{1'b0}};
         r_head_pc <= {PC_W{1'b0}};
         r_exp_pc  <= {PC_W{1'b0}};
      end else if (bus.redirect) begin
         r_head    <= {PTR_W{1'b0}};
         r_tail    <= {PTR_W{1'b0}};
         r_count   <= {CNT_W{1'b0}};
         r_head_pc <= bus.redirect_pc;
         r_exp_pc  <= bus.redirect_pc;
      end else begin
         r_count <= r_count + w_wr_cnt - w_pop_cnt;
         if (w_write) begin
            r_tail   <= r_tail + PTR_W'(w_wr_cnt);
            r_exp_pc <= bus.fetch_pc + PC_W'(FETCH_W / 8);
         end
         if (w_pop) begin
            r_head    <= r_head + PTR_W'(w_pop_cnt);
            r_head_pc <= r_head_pc + PC_W'({w_pop_cnt, 1'b0});
         end
      end
   end
endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: a parcel-queue model checked every cycle on the
// falling edge, plus hand-computed literal expectations at key points.
module tb_inst_buffer;
   localparam int FW = 64;
   localparam int DP = 16;
   localparam int PW = 64;
   localparam int NP = FW / 16;

   logic clk;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   inst_buffer_if #(.FETCH_W(FW), .PC_W(PW)) bus ();

   inst_buffer #(.FETCH_W(FW), .DEPTH(DP), .PC_W(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: a queue of parcels in program order plus the head and expected PCs.
   logic [15:0]   mq[$];
   logic [PW-1:0] m_head_pc;
   logic [PW-1:0] m_exp_pc;

   function automatic bit m_valid();
      if (mq.size() == 0) return 1'b0;
      if (mq[0][1:0] == 2'b11) return (mq.size() >= 2);
      return 1'b1;
   endfunction

   function automatic bit m_ready();
      return ((DP - mq.size()) >= NP) && !bus.redirect;
   endfunction

   function automatic logic [31:0] m_inst();
      if (mq[0][1:0] == 2'b11) return {mq[1], mq[0]};
      return {16'h0000, mq[0]};
   endfunction

   task automatic m_clear();
      mq.delete();
      m_head_pc = 64'h0;
      m_exp_pc  = 64'h0;
   endtask

   task automatic model_step();
      bit pop;
      bit acc;
      int o;
      if (bus.redirect) begin
         mq.delete();
         m_head_pc = bus.redirect_pc;
         m_exp_pc  = bus.redirect_pc;
      end else begin
         pop = m_valid() && bus.inst_ready;
         acc = bus.fetch_valid && m_ready();
         if (pop) begin
            if (mq[0][1:0] == 2'b11) begin
               void'(mq.pop_front());
               void'(mq.pop_front());
               m_head_pc = m_head_pc + 64'd4;
            end else begin
               void'(mq.pop_front());
               m_head_pc = m_head_pc + 64'd2;
            end
         end
         if (acc && (bus.fetch_pc == (m_exp_pc & ~64'h7))) begin
            o = int'(m_exp_pc[2:0]) / 2;
            for (int k = o; k < NP; k++) mq.push_back(bus.fetch_data[16*k +: 16]);
            m_exp_pc = bus.fetch_pc + 64'd8;
         end
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("inst_valid", {63'h0, bus.inst_valid}, {63'h0, m_valid()});
      chk("pc", bus.pc, m_head_pc);
      chk("fetch_ready", {63'h0, bus.fetch_ready}, {63'h0, m_ready()});
      if (m_valid()) begin
         chk("inst", {32'h0, bus.inst}, {32'h0, m_inst()});
         chk("inst_compressed", {63'h0, bus.inst_compressed}, {63'h0, (mq[0][1:0] != 2'b11)});
      end else if (mq.size() == 0) begin
         chk("inst_empty", {32'h0, bus.inst}, 64'h0);
         chk("comp_empty", {63'h0, bus.inst_compressed}, 64'h0);
      end
   end

   task automatic cycle();
      @(posedge clk);
      if (rst) m_clear();
      else model_step();
      #1;
   endtask

   task automatic offer(input logic [63:0] a, input logic [63:0] d);
      bus.fetch_valid = 1'b1;
      bus.fetch_pc    = a;
      bus.fetch_data  = d;
   endtask

   task automatic do_redirect(input logic [63:0] a);
      bus.redirect    = 1'b1;
      bus.redirect_pc = a;
      cycle();
      bus.redirect    = 1'b0;
   endtask

   task automatic idle(input int n, input bit rdy);
      bus.fetch_valid = 1'b0;
      bus.inst_ready  = rdy;
      for (int i = 0; i < n; i++) cycle();
   endtask

   function automatic logic [63:0] blk36(input int n);
      return {16'h00A0 + 16'(n), 16'h0013, 16'h00B0 + 16'(n), 16'h0013};
   endfunction

   initial begin
      logic [63:0] fpc;
      logic [63:0] d;
      bus.fetch_valid = 1'b0;
      bus.fetch_pc    = 64'h0;
      bus.fetch_data  = 64'h0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 64'h0;
      bus.inst_ready  = 1'b0;
      m_clear();
      rst = 1'b0;
      #1 rst = 1'b1;
      repeat (3) cycle();
      rst = 1'b0;
      cycle();
      chk("rst_inst_valid", {63'h0, bus.inst_valid}, 64'h0);
      chk("rst_pc", bus.pc, 64'h0);
      chk("rst_fetch_ready", {63'h0, bus.fetch_ready}, 64'h1);

      // Three instructions from one block, popped back to back.
      do_redirect(64'h1000);
      bus.inst_ready = 1'b1;
      offer(64'h1000, 64'h0000_0013_4581_4501);
      cycle();
      bus.fetch_valid = 1'b0;
      chk("t34_inst0", {32'h0, bus.inst}, 64'h4501);
      chk("t34_pc0", bus.pc, 64'h1000);
      chk("t34_comp0", {63'h0, bus.inst_compressed}, 64'h1);
      cycle();
      chk("t34_inst1", {32'h0, bus.inst}, 64'h4581);
      chk("t34_pc1", bus.pc, 64'h1002);
      cycle();
      chk("t34_inst2", {32'h0, bus.inst}, 64'h0000_0013);
      chk("t34_pc2", bus.pc, 64'h1004);
      chk("t34_comp2", {63'h0, bus.inst_compressed}, 64'h0);
      cycle();
      chk("t34_empty", {63'h0, bus.inst_valid}, 64'h0);

      // 32-bit instruction straddling two blocks after an unaligned redirect.
      do_redirect(64'h2006);
      offer(64'h2000, 64'h0013_1111_2222_3333);
      cycle();
      bus.fetch_valid = 1'b0;
      chk("t35_hold", {63'h0, bus.inst_valid}, 64'h0);
      chk("t35_hold_pc", bus.pc, 64'h2006);
      cycle();
      offer(64'h2008, 64'h0000_0001_4501_0000);
      cycle();
      bus.fetch_valid = 1'b0;
      chk("t35_valid", {63'h0, bus.inst_valid}, 64'h1);
      chk("t35_inst", {32'h0, bus.inst}, 64'h0000_0013);
      chk("t35_pc", bus.pc, 64'h2006);
      idle(6, 1'b1);

      // Fill to capacity, then free space one 32-bit instruction at a time.
      do_redirect(64'h5000);
      bus.inst_ready = 1'b0;
      for (int n = 0; n < 4; n++) begin
         offer(64'h5000 + 64'(8 * n), blk36(n));
         cycle();
      end
      bus.fetch_valid = 1'b0;
      chk("t36_full_ready", {63'h0, bus.fetch_ready}, 64'h0);
      chk("t36_full_inst", {32'h0, bus.inst}, 64'h00B0_0013);
      bus.inst_ready = 1'b1;
      cycle();
      bus.inst_ready = 1'b0;
      chk("t36_pop1_ready", {63'h0, bus.fetch_ready}, 64'h0);
      chk("t36_pop1_pc", bus.pc, 64'h5004);
      chk("t36_pop1_inst", {32'h0, bus.inst}, 64'h00A0_0013);
      bus.inst_ready = 1'b1;
      cycle();
      chk("t36_pop2_ready", {63'h0, bus.fetch_ready}, 64'h1);
      chk("t36_pop2_pc", bus.pc, 64'h5008);
      offer(64'h5020, blk36(4));
      cycle();
      idle(10, 1'b1);

      // Out-of-sequence block is swallowed without changing the stream.
      do_redirect(64'h1000);
      bus.inst_ready = 1'b0;
      offer(64'h1000, 64'h0000_0013_4581_4501);
      cycle();
      offer(64'h3000, 64'h1111_2222_3333_4445);
      chk("t37_ready", {63'h0, bus.fetch_ready}, 64'h1);
      cycle();
      offer(64'h1008, 64'h000D_0009_0005_0001);
      cycle();
      idle(3, 1'b1);
      chk("t37_next_pc", bus.pc, 64'h1008);
      chk("t37_next_inst", {32'h0, bus.inst}, 64'h0001);
      idle(5, 1'b1);

      // Redirect wins over a same-cycle fetch and pop.
      offer(64'h1010, 64'h0005_0005_0005_0005);
      cycle();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 64'h4000;
      offer(64'h1018, 64'h0009_0009_0009_0009);
      cycle();
      bus.redirect    = 1'b0;
      bus.fetch_valid = 1'b0;
      chk("t38_valid", {63'h0, bus.inst_valid}, 64'h0);
      chk("t38_pc", bus.pc, 64'h4000);
      bus.inst_ready = 1'b0;
      offer(64'h4000, 64'h0000_0013_4581_4501);
      cycle();
      bus.fetch_valid = 1'b0;
      chk("t38_loaded", {63'h0, bus.inst_valid}, 64'h1);
      rst = 1'b1;
      m_clear();
      #1;
      chk("t38_rst_valid", {63'h0, bus.inst_valid}, 64'h0);
      chk("t38_rst_pc", bus.pc, 64'h0);
      chk("t38_rst_inst", {32'h0, bus.inst}, 64'h0);
      chk("t38_rst_comp", {63'h0, bus.inst_compressed}, 64'h0);
      cycle();
      cycle();
      rst = 1'b0;
      cycle();

      // PC wrap across 2^64 with a straddling 32-bit instruction.
      do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
      bus.inst_ready = 1'b1;
      offer(64'hFFFF_FFFF_FFFF_FFF8, 64'h0013_4501_7777_7777);
      cycle();
      chk("wrap_inst0", {32'h0, bus.inst}, 64'h4501);
      chk("wrap_pc0", bus.pc, 64'hFFFF_FFFF_FFFF_FFFC);
      offer(64'h0, 64'h0001_0005_4581_0000);
      cycle();
      bus.fetch_valid = 1'b0;
      chk("wrap_inst1", {32'h0, bus.inst}, 64'h0000_0013);
      chk("wrap_pc1", bus.pc, 64'hFFFF_FFFF_FFFF_FFFE);
      cycle();
      chk("wrap_pc2", bus.pc, 64'h2);
      chk("wrap_inst2", {32'h0, bus.inst}, 64'h4581);
      idle(4, 1'b1);

      // Long mixed stream: throttled consumer, pointer wrap, one stray block.
      do_redirect(64'h8002);
      fpc = 64'h8000;
      for (int i = 0; i < 40; i++) begin
         for (int k = 0; k < NP; k++) d[16*k +: 16] = 16'((i * 4 + k) * 16'h1235 + 16'h0011);
         bus.inst_ready = (i % 3 != 1);
         if (i == 10) begin
            offer(64'h9999_0000, d);
         end else if (i % 4 != 3) begin
            offer(fpc, d);
         end else begin
            bus.fetch_valid = 1'b0;
         end
         @(posedge clk);
         if (bus.fetch_valid && m_ready() && bus.fetch_pc == fpc) fpc = fpc + 64'd8;
         model_step();
         #1;
      end
      idle(14, 1'b1);
      chk("mix_drained", {63'h0, bus.inst_valid}, {63'h0, m_valid()});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 Parameter FETCH_W, default 64, fetch block width in bits; multiple of 16, ≥32.
REQ-002 Parameter DEPTH, default 16, buffer capacity in 16-bit parcels; power of 2, ≥ 2*FETCH_W/16.
REQ-003 Parameter PC_W, default 64, address width.
REQ-004 Port: clk, in, 1, single clock; all state on rising edge.
REQ-005 Port: rst, in, 1, asynchronous active-high reset.
REQ-006 Port: fetch_valid, in, 1, fetch block offered.
REQ-007 Port: fetch_ready, out, 1, buffer accepts a block this cycle.
REQ-008 Port: fetch_pc, in, PC_W, address of block byte 0, aligned to FETCH_W/8.
REQ-009 Port: fetch_data, in, FETCH_W, block contents; parcel k = bits [16k+15:16k], little-endian.
REQ-010 Port: redirect, in, 1, flush and restart at redirect_pc.
REQ-011 Port: redirect_pc, in, PC_W, new fetch address; bit 0 is zero.
REQ-012 Port: inst_valid, out, 1, complete instruction at head.
REQ-013 Port: inst_ready, in, 1, consumer takes head instruction.
REQ-014 Port: inst, out, 32, instruction; compressed -> bits [31:16] zero.
REQ-015 Port: inst_compressed, out, 1, head instruction is 16-bit.
REQ-016 Port: pc, out, PC_W, address of head instruction.

Function
REQ-017 State: circular parcel array, head/tail pointers mod DEPTH, count 0..DEPTH, head_pc, exp_pc (next expected parcel address).
REQ-018 P = FETCH_W/16; fetch_ready = (DEPTH - count ≥ P) and not redirect, combinational.
REQ-019 Accept = fetch_valid & fetch_ready; block is in-sequence when fetch_pc == exp_pc with low log2(FETCH_W/8) bits cleared.
REQ-020 In-sequence accept: write parcels from offset o = exp_pc[log2(FETCH_W/8)-1:1] through P-1; count += P-o; exp_pc = fetch_pc + FETCH_W/8.
REQ-021 Out-of-sequence accept: block consumed and discarded; no state change.
REQ-022 Head parcel h; 32-bit when h[1:0]==2'b11, else compressed.
REQ-023 inst_valid = count≥1 for compressed, count≥2 for 32-bit; inst = {next parcel, h} or {16'h0, h}; outputs combinational from registered state.
REQ-024 Pop = inst_valid & inst_ready: head advances by 1 (compressed) or 2; head_pc += 2 or 4; count decremented.
REQ-025 Simultaneous accept and pop in one cycle: count = count + written - popped; both legal at full/empty boundaries per REQ-018/023.
REQ-026 32-bit instruction straddling blocks held (inst_valid 0) until second parcel written.
REQ-027 Pointer and PC arithmetic wrap modulo DEPTH and 2^PC_W respectively.
REQ-028 redirect has priority: next cycle count=0, head=tail=0, head_pc=exp_pc=redirect_pc; same-cycle fetch and pop ignored, inst_valid/inst_ready ignored.
REQ-029 inst_valid never asserted while count==0; fetch_ready never asserted when free < P.

Reset
REQ-030 rst asserted (asynchronously, any cycle, including mid-instruction or mid-block): count=0, head=tail=0, head_pc=0, exp_pc=0.
REQ-031 During/after reset: inst_valid=0, inst=0, inst_compressed=0, pc=0, fetch_ready=1 once rst deasserted.
REQ-032 Array contents need no reset; outputs must not depend on unwritten entries.

Verification
REQ-033 Reset release, no stimulus -> inst_valid=0, pc=0, fetch_ready=1.
REQ-034 redirect 0x1000; block 0x1000 data 0x0000_0013_4581_4501; inst_ready=1 -> 0x4501@0x1000 comp, 0x4581@0x1002 comp, 0x00000013@0x1004 not comp, then inst_valid=0.
REQ-035 redirect 0x2006; block 0x2000 parcel3=0x0013 -> inst_valid=0; block 0x2008 parcel0=0x0000 -> inst=0x00000013, pc=0x2006.
REQ-036 DEPTH=16, inst_ready=0, four in-sequence blocks -> count=16, fetch_ready=0; pop one 32-bit -> fetch_ready stays 0; pop another -> fetch_ready=1.
REQ-037 exp_pc 0x1008, block fetch_pc 0x3000 accepted -> discarded, count unchanged, exp_pc 0x1008.
REQ-038 redirect 0x4000 with fetch_valid=1 and pop same cycle -> next cycle count=0, inst_valid=0, pc=0x4000; rst mid-stream -> all outputs 0 immediately.
